// File: rtl/endec_sched.sv
// endec_sched: job scheduler / arbiter in front of the shared endec engine.
//
// Shares one convolutional encoder / Viterbi decoder engine between an
// encode client and a decode client. Arbitration is round-robin. The code
// configuration is latched at every grant and held for the whole job.
// Encode jobs get TAIL zero flush bits appended. The engine's done pulses
// are counted to detect job completion, and a watchdog aborts jobs that
// stall.
//
// Ports
//   clk, rst            : clock, asynchronous active-low reset
//   cfg_we/_code_rate/_gen_poly, cfg_err : configuration write, reject pulse
//   enc_req/_len/_bit/_valid/_ready      : encode job request and bit stream
//   enc_gnt/_done/_err                   : encode grant, completion, timeout
//   dec_req/_len/_frame/_valid/_ready    : decode job request and frame stream
//   dec_gnt/_done/_err                   : decode grant, completion, timeout
//   eng_en/_mode_sel/_code_rate/_gen_poly/_enc_bit/_dec_frame : engine drive
//   eng_enc_done, eng_dec_done           : engine done pulses
module endec_sched #(
  parameter int CL      = 9,
  parameter int NPOLY   = 3,
  parameter int TAIL    = 8,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cfg_we,
  input  logic                   cfg_code_rate,
  input  logic [NPOLY*CL-1:0]    cfg_gen_poly,
  output logic                   cfg_err,
  input  logic                   enc_req,
  input  logic [7:0]             enc_len,
  input  logic                   enc_bit,
  input  logic                   enc_valid,
  output logic                   enc_ready,
  output logic                   enc_gnt,
  output logic                   enc_done,
  output logic                   enc_err,
  input  logic                   dec_req,
  input  logic [3:0]             dec_len,
  input  logic [15:0]            dec_frame,
  input  logic                   dec_valid,
  output logic                   dec_ready,
  output logic                   dec_gnt,
  output logic                   dec_done,
  output logic                   dec_err,
  output logic                   eng_en,
  output logic                   eng_mode_sel,
  output logic                   eng_code_rate,
  output logic [NPOLY*CL-1:0]    eng_gen_poly,
  output logic                   eng_enc_bit,
  output logic [15:0]            eng_dec_frame,
  input  logic                   eng_enc_done,
  input  logic                   eng_dec_done
);

  localparam int PW   = NPOLY * CL;
  localparam int WD_W = $clog2(TIMEOUT + 1);
  localparam int AW   = $clog2(TAIL + 2);

  localparam logic [WD_W-1:0] TO_VAL    = WD_W'(TIMEOUT);
  localparam logic [AW-1:0]   FLUSH_END = AW'(TAIL - 1);
  localparam logic [9:0]      TAIL_CNT  = 10'(TAIL);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_GRANT     = 3'd1;
  localparam logic [2:0] S_ENC_RUN   = 3'd2;
  localparam logic [2:0] S_ENC_FLUSH = 3'd3;
  localparam logic [2:0] S_DEC_RUN   = 3'd4;
  localparam logic [2:0] S_WAIT      = 3'd5;
  localparam logic [2:0] S_FINISH    = 3'd6;
  localparam logic [2:0] S_ABORT     = 3'd7;

  logic [2:0]      state_reg, state_next;
  logic            cfg_rate_reg;
  logic [PW-1:0]   cfg_poly_reg;
  logic            eng_rate_reg;
  logic [PW-1:0]   eng_poly_reg;
  logic            mode_reg;       // owner of the current/last job, 1 = decode
  logic            last_dec_reg;   // round-robin pointer, 1 = decode served last
  logic            cfg_err_reg;
  logic [8:0]      len_reg;        // input items for the job (bits or frames)
  logic [8:0]      in_cnt_reg;
  logic [9:0]      done_cnt_reg;
  logic [WD_W-1:0] wdog_reg;       // cycles since the last accepted input/done
  logic [AW-1:0]   aux_reg;        // flush length and abort hold counter

  logic            req_any;
  logic            pick_dec;
  logic            accept;
  logic            last_input;
  logic            counting;
  logic            done_hit;
  logic [9:0]      done_sum;
  logic [9:0]      done_target;
  logic            done_reached;
  logic            wdog_on;
  logic [WD_W-1:0] wdog_inc;
  logic            wdog_expired;
  logic            job_active;

  assign req_any  = enc_req | dec_req;
  // Decode wins when it asks alone, or on a tie when encode was served last.
  assign pick_dec = dec_req & (~enc_req | ~last_dec_reg);

  assign accept = ((state_reg == S_ENC_RUN) & enc_valid) |
                  ((state_reg == S_DEC_RUN) & dec_valid);
  assign last_input = accept & ((in_cnt_reg + 9'd1) == len_reg);

  // Done pulses are tallied from the first input cycle onwards so that
  // early completions are carried into WAIT.
  assign counting = (state_reg == S_ENC_RUN) | (state_reg == S_ENC_FLUSH) |
                    (state_reg == S_DEC_RUN) | (state_reg == S_WAIT);
  assign done_hit    = counting & (mode_reg ? eng_dec_done : eng_enc_done);
  assign done_sum    = done_cnt_reg + {9'd0, done_hit};
  assign done_target = mode_reg ? {1'b0, len_reg} : ({1'b0, len_reg} + TAIL_CNT);
  assign done_reached = (done_sum >= done_target);

  // The flush phase has a fixed length, so the watchdog is parked there.
  assign wdog_on = (state_reg == S_ENC_RUN) | (state_reg == S_DEC_RUN) |
                   (state_reg == S_WAIT);
  assign wdog_inc = ((accept | done_hit) ? '0 : wdog_reg) + WD_W'(1);
  assign wdog_expired = wdog_on & (wdog_inc == TO_VAL);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:      if (req_any) state_next = S_GRANT;
      S_GRANT:     state_next = mode_reg ? S_DEC_RUN : S_ENC_RUN;
      S_ENC_RUN: begin
        if (last_input)        state_next = S_ENC_FLUSH;
        else if (wdog_expired) state_next = S_ABORT;
      end
      S_ENC_FLUSH: if (aux_reg == FLUSH_END) state_next = S_WAIT;
      S_DEC_RUN: begin
        if (last_input)        state_next = S_WAIT;
        else if (wdog_expired) state_next = S_ABORT;
      end
      S_WAIT: begin
        if (done_reached)      state_next = S_FINISH;
        else if (wdog_expired) state_next = S_ABORT;
      end
      S_FINISH:    state_next = S_IDLE;
      S_ABORT:     if (aux_reg[0]) state_next = S_IDLE;
      default:     state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_IDLE;
      cfg_rate_reg <= 1'b0;
      cfg_poly_reg <= '0;
      eng_rate_reg <= 1'b0;
      eng_poly_reg <= '0;
      mode_reg     <= 1'b0;
      last_dec_reg <= 1'b1;
      cfg_err_reg  <= 1'b0;
      len_reg      <= '0;
      in_cnt_reg   <= '0;
      done_cnt_reg <= '0;
      wdog_reg     <= '0;
      aux_reg      <= '0;
    end else begin
      state_reg   <= state_next;
      cfg_err_reg <= cfg_we & (state_reg != S_IDLE);

      if (state_reg == S_IDLE) begin
        if (cfg_we) begin
          cfg_rate_reg <= cfg_code_rate;
          cfg_poly_reg <= cfg_gen_poly;
        end
        if (req_any) begin
          mode_reg     <= pick_dec;
          last_dec_reg <= pick_dec;
          if (pick_dec) len_reg <= (dec_len == 4'd0) ? 9'd16 : {5'd0, dec_len};
          else          len_reg <= (enc_len == 8'd0) ? 9'd256 : {1'b0, enc_len};
          // A same-cycle write is forwarded so the job sees the new value.
          eng_rate_reg <= cfg_we ? cfg_code_rate : cfg_rate_reg;
          eng_poly_reg <= cfg_we ? cfg_gen_poly : cfg_poly_reg;
        end
      end

      if (state_reg == S_GRANT) begin
        in_cnt_reg   <= '0;
        done_cnt_reg <= '0;
        wdog_reg     <= '0;
        aux_reg      <= '0;
      end else begin
        if (accept)   in_cnt_reg   <= in_cnt_reg + 9'd1;
        if (done_hit) done_cnt_reg <= done_sum;
        if (wdog_on)                         wdog_reg <= wdog_inc;
        else if (state_reg == S_ENC_FLUSH)   wdog_reg <= '0;
        if ((state_reg == S_ENC_FLUSH) || (state_reg == S_ABORT))
          aux_reg <= aux_reg + AW'(1);
        else if (state_next == S_ABORT)
          aux_reg <= '0;
      end
    end
  end

  // Job-level outputs decode straight from the state register so that an
  // asynchronous reset drops them immediately.
  assign job_active = (state_reg != S_IDLE) & (state_reg != S_ABORT);

  assign enc_gnt   = job_active & ~mode_reg;
  assign dec_gnt   = job_active & mode_reg;
  assign enc_ready = (state_reg == S_ENC_RUN);
  assign dec_ready = (state_reg == S_DEC_RUN);
  assign enc_done  = (state_reg == S_FINISH) & ~mode_reg;
  assign dec_done  = (state_reg == S_FINISH) & mode_reg;
  assign enc_err   = (state_reg == S_ABORT) & (aux_reg == '0) & ~mode_reg;
  assign dec_err   = (state_reg == S_ABORT) & (aux_reg == '0) & mode_reg;
  assign cfg_err   = cfg_err_reg;

  assign eng_en        = ((state_reg == S_ENC_RUN) & enc_valid) |
                         (state_reg == S_ENC_FLUSH) |
                         ((state_reg == S_DEC_RUN) & dec_valid);
  assign eng_enc_bit   = (state_reg == S_ENC_RUN) & enc_valid & enc_bit;
  assign eng_dec_frame = ((state_reg == S_DEC_RUN) && dec_valid) ? dec_frame : 16'd0;
  assign eng_mode_sel  = mode_reg;
  assign eng_code_rate = eng_rate_reg;
  assign eng_gen_poly  = eng_poly_reg;

endmodule
